perm_server: RTL and testbench
==============================

PERM_SERVER -- requirements
Module: perm_server

Interface
REQ-001 Parameter: MAX_REJECT, default 4, consecutive rejected draws per shuffle step before fallback.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 restart  input  1  single-cycle pulse; discard current permutation and reshuffle.
REQ-005 req  input  1  single-cycle request for the next number.
REQ-006 rnd_num  input  3  random draw from the external LFSR, sampled every cycle.
REQ-007 selected_number  output  3  last number served; holds between requests.
REQ-008 done  output  1  one-cycle pulse: selected_number updated for the accepted req.
REQ-009 all_selected  output  1  all 8 numbers served; sticky.
REQ-010 busy  output  1  high during INIT and SHUFFLE.

Function
REQ-011 States SHALL be INIT, SHUFFLE, READY, RESPOND and EXHAUSTED, encoded in 3 bits.
REQ-012 INIT SHALL last 1 cycle, load table[k]=k for k=0..7, set step index i=7, clear reject count, and go to SHUFFLE.
REQ-013 Each SHUFFLE cycle SHALL accept j=rnd_num if rnd_num<=i, swap table[i] with table[j], decrement i and clear the reject count.
REQ-014 If rnd_num>i, SHUFFLE SHALL increment the reject count and leave the table unchanged.
REQ-015 On the MAX_REJECT-th consecutive reject, SHUFFLE SHALL use j=i instead (no swap) and advance i.
REQ-016 The shuffle step at i=1 SHALL be the last; the following cycle the state SHALL be READY.
REQ-017 A req arriving during INIT or SHUFFLE SHALL be latched as pending, and pending SHALL be serviced on the first READY cycle as if req were high.
REQ-018 In READY, req or pending SHALL, on the next cycle, set selected_number=table[ptr], pulse done, increment the 3-bit serve count ptr, clear pending, and enter RESPOND.
REQ-019 Request-to-done latency SHALL be exactly 1 cycle from READY.
REQ-020 RESPOND SHALL last 1 cycle and go to READY if ptr has served fewer than 8 numbers.
REQ-021 After the 8th serve, RESPOND SHALL go to EXHAUSTED.
REQ-022 all_selected SHALL rise in the same cycle as the 8th done pulse.
REQ-023 req SHALL be ignored in RESPOND and EXHAUSTED, with no done, no count change and no pending set.
REQ-024 restart SHALL take effect from any state and enter INIT next cycle.
REQ-025 restart SHALL clear ptr, pending, done and all_selected, and SHALL leave selected_number unchanged.
REQ-026 When restart and req coincide, restart SHALL win and req SHALL be dropped.
REQ-027 busy SHALL equal (state==INIT or state==SHUFFLE).
REQ-028 The served sequence SHALL be a permutation of 0..7 with no repeats for every rnd_num stream.

Reset
REQ-029 While rstn=0 at a clk edge: state=INIT, selected_number=0, done=0, all_selected=0, busy=1, ptr=0, pending=0, reject count=0.
REQ-030 Reset asserted mid-shuffle or mid-serve SHALL abandon all progress, and the first post-reset cycle SHALL be INIT.

Structure
REQ-031 The state encodings, table depth (8) and MAX_REJECT default SHALL live in the shared defines header.
REQ-032 The 8x3 table with swap port SHALL be one sub-module, perm_table: synchronous swap of entries (i, j) plus a combinational read port.
REQ-033 perm_server SHALL contain the FSM, counters and output registers.

Verification
REQ-034 Scenario 1, rnd_num=0 throughout shuffle: busy SHALL be high for 8 cycles after reset release, then 8 reqs spaced 3 cycles apart SHALL give selected_number 1,2,3,4,5,6,7,0, with all_selected rising on the 8th done.
REQ-035 Scenario 2, rnd_num=7 throughout with MAX_REJECT=4: SHUFFLE SHALL last 25 cycles, and the served order SHALL be 0..7.
REQ-036 Scenario 3, req pulsed 2 cycles after reset release: exactly one done SHALL appear, 1 cycle after the first READY cycle.
REQ-037 Scenario 4, after all_selected, 3 further req pulses: no done, selected_number and all_selected unchanged.
REQ-038 Scenario 5, restart together with req after the 4th serve: no done, all_selected=0, busy=1 next cycle, then a fresh 8-number permutation.
REQ-039 Scenario 6, random rnd_num over 1000 restarts: every served set SHALL equal {0..7}, with no repeats and done exactly 8 times per restart.

Source files
------------

// File: rtl/perm_server_pkg.sv
// Shared constants for the permutation server: state encodings, table geometry
// and the default reject budget.
package perm_server_pkg;

  localparam int unsigned TABLE_DEPTH        = 8;
  localparam int unsigned IDX_W              = 3;
  localparam int unsigned STATE_W            = 3;
  localparam int unsigned MAX_REJECT_DEFAULT = 4;

  localparam logic [STATE_W-1:0] ST_INIT      = 3'd0;
  localparam logic [STATE_W-1:0] ST_SHUFFLE   = 3'd1;
  localparam logic [STATE_W-1:0] ST_READY     = 3'd2;
  localparam logic [STATE_W-1:0] ST_RESPOND   = 3'd3;
  localparam logic [STATE_W-1:0] ST_EXHAUSTED = 3'd4;

  localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;

  // Busy covers table construction: INIT and SHUFFLE.
  function automatic logic is_busy_state(input logic [STATE_W-1:0] st);
    return (st == ST_INIT) || (st == ST_SHUFFLE);
  endfunction

endpackage

// File: rtl/perm_table.sv
// 8x3 permutation table: identity load, synchronous swap of entries (i, j)
// and a combinational read port.
module perm_table
  import perm_server_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       init,
  input  logic       swap_en,
  input  logic [2:0] idx_i,
  input  logic [2:0] idx_j,
  input  logic [2:0] rd_addr,
  output logic [2:0] rd_data
);

  logic [IDX_W-1:0] tbl_q [TABLE_DEPTH];
  logic [IDX_W-1:0] tbl_d [TABLE_DEPTH];

  // Init has priority over swap; a swap with i == j leaves the entry intact.
  always_comb begin
    tbl_d = tbl_q;
    if (init) begin
      for (int unsigned k = 0; k < TABLE_DEPTH; k++) begin
        tbl_d[k] = IDX_W'(k);
      end
    end else if (swap_en) begin
      tbl_d[idx_i] = tbl_q[idx_j];
      tbl_d[idx_j] = tbl_q[idx_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < TABLE_DEPTH; k++) begin
        tbl_q[k] <= IDX_W'(k);
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rd_data = tbl_q[rd_addr];

endmodule

// File: rtl/perm_server.sv
// Serves a random permutation of 0..7 one number per request, building it
// with a Fisher-Yates shuffle driven by an external random draw.
module perm_server
  import perm_server_pkg::*;
#(
  parameter int unsigned MAX_REJECT = MAX_REJECT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       restart,
  input  logic       req,
  input  logic [2:0] rnd_num,
  output logic [2:0] selected_number,
  output logic       done,
  output logic       all_selected,
  output logic       busy
);

  localparam int unsigned     REJ_W    = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;
  localparam logic [REJ_W-1:0] REJ_LAST = REJ_W'(MAX_REJECT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REJ_W-1:0]   rej_q, rej_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               pending_q, pending_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               done_q, done_d;
  logic               all_q, all_d;
  logic               busy_q, busy_d;

  logic               tbl_init;
  logic               tbl_swap;
  logic [IDX_W-1:0]   tbl_rd;

  perm_table u_table (
    .clk     (clk),
    .rstn    (rstn),
    .init    (tbl_init),
    .swap_en (tbl_swap),
    .idx_i   (idx_q),
    .idx_j   (rnd_num),
    .rd_addr (ptr_q),
    .rd_data (tbl_rd)
  );

  // Next-state, counters and output register inputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rej_d     = rej_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    all_d     = all_q;
    tbl_init  = 1'b0;
    tbl_swap  = 1'b0;

    if (restart) begin
      state_d   = ST_INIT;
      ptr_d     = '0;
      pending_d = 1'b0;
      all_d     = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          tbl_init = 1'b1;
          idx_d    = IDX_LAST;
          rej_d    = '0;
          state_d  = ST_SHUFFLE;
          if (req) pending_d = 1'b1;
        end

        ST_SHUFFLE: begin
          if (req) pending_d = 1'b1;
          // Accepted draw swaps; an exhausted reject budget keeps table[i] in place.
          if (rnd_num <= idx_q || rej_q == REJ_LAST) begin
            tbl_swap = (rnd_num <= idx_q);
            idx_d    = idx_q - 1'b1;
            rej_d    = '0;
            if (idx_q == 3'd1) state_d = ST_READY;
          end else begin
            rej_d = rej_q + 1'b1;
          end
        end

        ST_READY: begin
          if (req || pending_q) begin
            sel_d     = tbl_rd;
            done_d    = 1'b1;
            ptr_d     = ptr_q + 1'b1;
            pending_d = 1'b0;
            all_d     = (ptr_q == IDX_LAST);
            state_d   = ST_RESPOND;
          end
        end

        ST_RESPOND: begin
          state_d = all_q ? ST_EXHAUSTED : ST_READY;
        end

        ST_EXHAUSTED: begin
          state_d = ST_EXHAUSTED;
        end

        default: begin
          state_d = ST_INIT;
        end
      endcase
    end

    busy_d = is_busy_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_INIT;
      idx_q     <= IDX_LAST;
      rej_q     <= '0;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      sel_q     <= '0;
      done_q    <= 1'b0;
      all_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rej_q     <= rej_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      all_q     <= all_d;
      busy_q    <= busy_d;
    end
  end

  assign selected_number = sel_q;
  assign done            = done_q;
  assign all_selected    = all_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_perm_server.sv
// Directed cycle vectors plus hand-written request/restart sequences and a
// randomized permutation-property sweep for perm_server.
module tb_perm_server;

  logic       clk = 1'b0;
  logic       rstn;
  logic       restart;
  logic       req;
  logic [2:0] rnd_num;
  logic [2:0] selected_number;
  logic       done;
  logic       all_selected;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perm_server #(.MAX_REJECT(4)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .restart         (restart),
    .req             (req),
    .rnd_num         (rnd_num),
    .selected_number (selected_number),
    .done            (done),
    .all_selected    (all_selected),
    .busy            (busy)
  );

  typedef struct {
    logic       rstn;
    logic       restart;
    logic       req;
    logic [2:0] rnd;
    logic [2:0] exp_sel;
    logic       exp_done;
    logic       exp_all;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  logic [2:0] ord_rot [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [2:0] ord_id  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r_n, input logic rs, input logic rq, input logic [2:0] rn,
                     input logic [2:0] es, input logic ed, input logic ea, input logic eb);
    vec_t v;
    v.rstn = r_n; v.restart = rs; v.req = rq; v.rnd = rn;
    v.exp_sel = es; v.exp_done = ed; v.exp_all = ea; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  // Two reset cycles, n_busy busy cycles, then the first READY cycle.
  task automatic add_boot(input logic [2:0] rn, input int n_busy);
    add(1'b0, 1'b0, 1'b0, rn, 3'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, rn, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < n_busy; k++) add(1'b1, 1'b0, 1'b0, rn, 3'd0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, rn, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Requests spaced three cycles apart for serves from..to-1.
  task automatic add_serves(input logic [2:0] rn, input logic [2:0] order [8],
                            input int from, input int to);
    for (int k = from; k < to; k++) begin
      add(1'b1, 1'b0, 1'b1, rn, order[k], 1'b1, (k == 7), 1'b0);
      add(1'b1, 1'b0, 1'b0, rn, order[k], 1'b0, (k == 7), 1'b0);
      add(1'b1, 1'b0, 1'b0, rn, order[k], 1'b0, (k == 7), 1'b0);
    end
  endtask

  initial begin
    int done_cnt;
    int done_edge;
    int ready_edge;

    rstn = 1'b0; restart = 1'b0; req = 1'b0; rnd_num = 3'd0;

    // rnd_num stuck at 0: rotated order.
    add_boot(3'd0, 7);
    add_serves(3'd0, ord_rot, 0, 8);
    // rnd_num stuck at 7: every step below 7 falls back, identity order.
    add_boot(3'd7, 25);
    add_serves(3'd7, ord_id, 0, 8);
    // Requests after exhaustion are ignored.
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0);
    end
    // Reset mid-shuffle, then restart colliding with req after the 4th serve.
    add(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    add_boot(3'd0, 7);
    add_serves(3'd0, ord_rot, 0, 4);
    add(1'b1, 1'b1, 1'b1, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) add(1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
    add_serves(3'd0, ord_rot, 0, 8);

    foreach (vecs[n]) begin
      rstn = vecs[n].rstn; restart = vecs[n].restart; req = vecs[n].req; rnd_num = vecs[n].rnd;
      @(posedge clk); #1;
      check($sformatf("vec%0d sel", n), 32'(selected_number), 32'(vecs[n].exp_sel));
      check($sformatf("vec%0d done", n), 32'(done), 32'(vecs[n].exp_done));
      check($sformatf("vec%0d all", n), 32'(all_selected), 32'(vecs[n].exp_all));
      check($sformatf("vec%0d busy", n), 32'(busy), 32'(vecs[n].exp_busy));
    end
    restart = 1'b0; req = 1'b0;

    // Request during shuffle is held pending and served once.
    rstn = 1'b0; rnd_num = 3'd0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    done_cnt = 0; done_edge = -1; ready_edge = -1;
    for (int e = 1; e <= 20; e++) begin
      req = (e == 3);
      @(posedge clk); #1;
      if (!busy && ready_edge < 0) ready_edge = e;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
    end
    req = 1'b0;
    check("pending done count", 32'(done_cnt), 32'd1);
    check("pending ready edge", 32'(ready_edge), 32'd8);
    check("pending done edge", 32'(done_edge), 32'd9);
    check("pending sel", 32'(selected_number), 32'd1);

    // Random draws: every restart must serve each of 0..7 exactly once.
    for (int r = 0; r < 1000; r++) begin
      logic [7:0] seen;
      int         dones;
      int         t;
      seen = 8'h00; dones = 0; t = 0;
      restart = 1'b1; rnd_num = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      restart = 1'b0;
      while (busy && t < 64) begin
        rnd_num = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        t++;
      end
      for (int k = 0; k < 9; k++) begin
        req = 1'b1; rnd_num = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        req = 1'b0;
        if (done) begin
          dones++;
          if (seen[selected_number]) seen = 8'h00;
          else seen[selected_number] = 1'b1;
        end
        @(posedge clk); #1;
      end
      check($sformatf("rand%0d set", r), 32'(seen), 32'hFF);
      check($sformatf("rand%0d dones", r), 32'(dones), 32'd8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
